// File: rtl/cpuc_multi_port_ram.sv
// N-port byte-enabled RAM with fixed per-byte write priority (highest port wins),
// collision/out-of-range flags, 0/1-cycle read latency and a post-reset clear walk.
module cpuc_multi_port_ram #(
  parameter int NUM_PORTS      = 4,
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_SIZE       = 256,
  parameter int RD_LATENCY     = 0,
  parameter int RDW_NEW        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]     address,
  input  logic [NUM_PORTS-1:0]                     wren,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0]   byteen,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]     data,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]     q,
  output logic                                     ready,
  output logic [NUM_PORTS-1:0]                     collision,
  output logic [NUM_PORTS-1:0]                     oob
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [ADDR_WIDTH:0]   MEM_SIZE_W = (ADDR_WIDTH + 1)'(MEM_SIZE);
  localparam logic [ADDR_WIDTH-1:0] CLR_LAST   = ADDR_WIDTH'(MEM_SIZE - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
  logic                    ready_q, ready_d;
  logic [NUM_PORTS-1:0]    collision_q, collision_d;
  logic [NUM_PORTS-1:0]    oob_q, oob_d;

  logic [DATA_WIDTH-1:0]   mem [MEM_SIZE];

  logic                                 accept;
  logic                                 clr_we;
  logic [NUM_PORTS-1:0]                 inb;
  logic [NUM_PORTS-1:0][IDX_W-1:0]      idx;
  logic [NUM_PORTS-1:0][LANES-1:0]      we_byte;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rd_word;

  // Port traffic is ignored entirely while the clear walk owns the array.
  assign accept = ready_q & ~rst;
  assign clr_we = (state_q == ST_CLEAR) & ~rst;
  assign ready  = ready_q;
  assign collision = collision_q;
  assign oob       = oob_q;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (state_q == ST_CLEAR) begin
      clr_addr_d = clr_addr_q + 1'b1;
      if (clr_addr_q == CLR_LAST) begin
        state_d = ST_READY;
      end
    end
    ready_d = (state_d == ST_READY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_addr_q  <= '0;
      ready_q     <= 1'b0;
      collision_q <= '0;
      oob_q       <= '0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      ready_q     <= ready_d;
      collision_q <= collision_d;
      oob_q       <= oob_d;
    end
  end

  // Ascending port order: the last assignment (highest port) wins each byte.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr_q[IDX_W-1:0]] <= '0;
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      for (int b = 0; b < LANES; b++) begin
        if (we_byte[i][b]) begin
          mem[idx[i]][8*b +: 8] <= data[i][8*b +: 8];
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      logic col;

      assign inb[gi]     = ({1'b0, address[gi]} < MEM_SIZE_W);
      assign idx[gi]     = address[gi][IDX_W-1:0];
      assign we_byte[gi] = {LANES{accept & wren[gi] & inb[gi]}} & byteen[gi];
      assign rd_word[gi] = inb[gi] ? mem[idx[gi]] : '0;
      assign oob_d[gi]   = accept & ~inb[gi];

      always_comb begin
        col = 1'b0;
        for (int j = gi + 1; j < NUM_PORTS; j++) begin
          if (address[j] == address[gi]) begin
            col = col | (|(we_byte[gi] & we_byte[j]));
          end
        end
      end
      assign collision_d[gi] = col;

      if (RD_LATENCY == 0) begin : g_comb_rd
        assign q[gi] = ready_q ? rd_word[gi] : '0;
      end else begin : g_reg_rd
        logic [DATA_WIDTH-1:0] q_q, q_d, rd_sel;

        if (RDW_NEW != 0) begin : g_new
          // Forward this cycle's winning bytes so the read sees the post-write word.
          always_comb begin
            rd_sel = rd_word[gi];
            for (int j = 0; j < NUM_PORTS; j++) begin
              for (int b = 0; b < LANES; b++) begin
                if (we_byte[j][b] && inb[gi] && (address[j] == address[gi])) begin
                  rd_sel[8*b +: 8] = data[j][8*b +: 8];
                end
              end
            end
          end
        end else begin : g_old
          assign rd_sel = rd_word[gi];
        end

        assign q_d = ready_q ? rd_sel : '0;

        always_ff @(posedge clk) begin
          if (rst) begin
            q_q <= '0;
          end else begin
            q_q <= q_d;
          end
        end
        assign q[gi] = q_q;
      end
    end
  endgenerate

endmodule
